// File: rtl/serial_subtract_ctrl_pkg.sv
// rtl/serial_subtract_ctrl_pkg.sv - state encodings and default width for the bit-serial subtractor
package serial_subtract_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtract_ctrl_fs_bit_cell.sv
// rtl/serial_subtract_ctrl_fs_bit_cell.sv - combinational 1-bit full subtractor cell
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic borrowin,
  output logic diff,
  output logic borrowOut
);

  assign diff      = a ^ b ^ borrowin;
  assign borrowOut = (~a & (b | borrowin)) | (b & borrowin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// rtl/serial_subtract_ctrl.sv - LSB-first bit-serial subtractor sequencing one shared full-subtract cell
module serial_subtract_ctrl
  import serial_subtract_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             brw;
  logic [CNTW-1:0]  cnt;
  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;

  fs_bit_cell u_cell (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .borrowin (brw),
    .diff     (cell_d),
    .borrowOut(cell_bo)
  );

  assign last_bit = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Unused encodings fall to the default branch and return to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = start ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        state_d = last_bit ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      brw       <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      borrowOut <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= borrowin;
            cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          r_sh <= {cell_d, r_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= cell_bo;
          cnt  <= cnt + 1'b1;
          // Outputs only move on the final bit so they hold steady otherwise.
          if (last_bit) begin
            diff      <= {cell_d, r_sh[WIDTH-1:1]};
            borrowOut <= cell_bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// tb/tb_serial_subtract_ctrl.sv - self-checking bench for serial_subtract_ctrl (WIDTH=8)
module tb_serial_subtract_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrowin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrowOut;

  int nvec = 0;
  int nmis = 0;
  int done_cnt = 0;
  int both_cnt = 0;
  int accept_cnt = 0;

  serial_subtract_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .borrowin (borrowin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrowOut(borrowOut)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) both_cnt++;
  end

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] exp_diff;
    logic         exp_bo;
  } vec_t;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bin);
    int r;
    r = int'(x) - int'(y) - int'(bin);
    return (W+1)'(r < 0 ? r + (1 << (W+1)) : r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation from IDLE; returns the done latency (edges after acceptance) and busy cycles.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                       output logic [W-1:0] rd, output logic rbo, output int lat, output int bcnt);
    @(negedge clk);
    a = xa; b = xb; borrowin = xbin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    accept_cnt++;
    a = ~xa; b = ~xb; borrowin = ~xbin;
    lat = -1;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
    rd  = diff;
    rbo = borrowOut;
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs[7];
  logic [W-1:0] rd;
  logic [W-1:0] held;
  logic         rbo;
  logic [W:0]   m;
  int           lat;
  int           bcnt;
  int           k;
  int           dq[$];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};

    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_diff", 32'(diff), 0);
    chk("reset_bo", 32'(borrowOut), 0);
    #12 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, rd, rbo, lat, bcnt);
      chk($sformatf("tbl%0d_diff", i), 32'(rd), 32'(vecs[i].exp_diff));
      chk($sformatf("tbl%0d_bo", i), 32'(rbo), 32'(vecs[i].exp_bo));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 8);
      chk($sformatf("tbl%0d_busy", i), 32'(bcnt), 8);
    end

    // start re-pulsed mid-SHIFT is ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h23; borrowin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 a = 8'h01; b = 8'hF0; borrowin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (k = 5; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 8);
    chk("ign_diff", 32'(diff), 32'h37);
    chk("ign_bo", 32'(borrowOut), 0);
    held = diff;
    repeat (4) @(posedge clk);
    #1;
    chk("ign_hold_diff", 32'(diff), 32'(held));
    chk("ign_idle_busy", 32'(busy), 0);

    // start held high: done after edges 8, 18, 28
    @(negedge clk);
    a = 8'h33; b = 8'h11; borrowin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (k = 1; k <= 29; k++) begin
      @(posedge clk);
      #1;
      if (done) dq.push_back(k);
    end
    start = 1'b0;
    chk("held_ndone", 32'(dq.size()), 3);
    if (dq.size() == 3) begin
      chk("held_d0", 32'(dq[0]), 8);
      chk("held_d1", 32'(dq[1]), 18);
      chk("held_d2", 32'(dq[2]), 28);
    end
    chk("held_diff", 32'(diff), 32'h22);
    repeat (3) @(posedge clk);

    // async reset at SHIFT cycle 4
    @(negedge clk);
    a = 8'hC4; b = 8'h21; borrowin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_diff", 32'(diff), 0);
    chk("arst_bo", 32'(borrowOut), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) @(posedge clk);
    #1 chk("arst_no_done", 32'(done_cnt), 0);
    do_op(8'hC4, 8'h21, 1'b1, rd, rbo, lat, bcnt);
    chk("arst_next_diff", 32'(rd), 32'hA2);
    chk("arst_next_bo", 32'(rbo), 0);
    chk("arst_next_lat", 32'(lat), 8);

    // randomized against the arithmetic model
    done_cnt = 0;
    accept_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      m    = ref_sub(ra, rb, rbin);
      do_op(ra, rb, rbin, rd, rbo, lat, bcnt);
      chk($sformatf("rnd%0d_diff a=%0h b=%0h bi=%0d", i, ra, rb, rbin), 32'(rd), 32'(m[W-1:0]));
      chk($sformatf("rnd%0d_bo", i), 32'(rbo), 32'(m[W]));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 8);
    end
    chk("rnd_done_vs_accept", 32'(done_cnt), 32'(accept_cnt));
    chk("busy_done_exclusive", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
